// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - GPR write-back arbiter (ALU/LSU/MUL -> one write port), optional GPR_WB_SCOREBOARD_EN busy scoreboard
module gpr_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic [4:0]  mul_rd,
  input  logic [31:0] mul_data,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic [31:0] busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] lsu_cnt;
  logic [CW-1:0] mul_cnt;
  logic          lsu_starved;
  logic          mul_starved;
  logic          gnt_alu;
  logic          gnt_lsu;
  logic          gnt_mul;
  logic          accept;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;

  // Grant selection: starved LSU, starved MUL, then fixed ALU > LSU > MUL; nothing while in reset
  always_comb begin
    gnt_alu     = 1'b0;
    gnt_lsu     = 1'b0;
    gnt_mul     = 1'b0;
    lsu_starved = lsu_valid && (lsu_cnt == LIMIT);
    mul_starved = mul_valid && (mul_cnt == LIMIT);
    if (rst_n) begin
      if (lsu_starved)      gnt_lsu = 1'b1;
      else if (mul_starved) gnt_mul = 1'b1;
      else if (alu_valid)   gnt_alu = 1'b1;
      else if (lsu_valid)   gnt_lsu = 1'b1;
      else if (mul_valid)   gnt_mul = 1'b1;
    end
  end

  assign alu_ready = gnt_alu;
  assign lsu_ready = gnt_lsu;
  assign mul_ready = gnt_mul;
  assign accept    = gnt_alu | gnt_lsu | gnt_mul;

  // Route the granted source's destination and result toward the output register
  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (gnt_lsu) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end else if (gnt_mul) begin
      sel_rd   = mul_rd;
      sel_data = mul_data;
    end
  end

  // Aging counters: count lost cycles, saturate at the limit, clear on accept or when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_cnt <= '0;
      mul_cnt <= '0;
    end else begin
      if (!lsu_valid || gnt_lsu)  lsu_cnt <= '0;
      else if (lsu_cnt != LIMIT)  lsu_cnt <= lsu_cnt + CW'(1);
      if (!mul_valid || gnt_mul)  mul_cnt <= '0;
      else if (mul_cnt != LIMIT)  mul_cnt <= mul_cnt + CW'(1);
    end
  end

  // Write port register: one-cycle pulse per accepted result, x0 writes suppressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= accept && (sel_rd != 5'd0);
      if (accept) begin
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
      end
    end
  end

`ifdef GPR_WB_SCOREBOARD_EN
  logic [31:1] busy_q;

  // Busy bits: set on issue, clear on write-back; a same-edge issue wins over the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        busy_q[i] <= (busy_q[i] && !(wb_we && (wb_rd == 5'(i))))
                     || (iss_valid && (iss_rd == 5'(i)));
      end
    end
  end

  assign busy = {busy_q, 1'b0};
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_rd};
  assign busy       = '0;
`endif

endmodule
